// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, register x0 index
// and the bundled per-stage control word.
package pipe_pkg;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEMWAIT    = 2'd1,
        REDIR_PEND = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic pc_stall;
        logic fd_stall;
        logic fd_flush;
        logic de_stall;
        logic de_flush;
        logic em_stall;
        logic mw_flush;
    } hz_ctrl_t;

endpackage

// File: rtl/hz_luse_det.sv
// Load-use comparator: flags a decode source that depends on a load in EX.
// Purely combinational; x0 never forms a dependency.
module hz_luse_det
    import pipe_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_is_load,
    output logic       luse
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
    assign luse    = ex_is_load && (ex_rd != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: combinational stage controls from a
// small FSM (RUN/MEMWAIT/REDIR_PEND). HAZARD_PERF_EN adds saturating counters.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_redirect,
    output logic             pc_stall,
    output logic             fd_stall,
    output logic             fd_flush,
    output logic             de_stall,
    output logic             de_flush,
    output logic             em_stall,
    output logic             mw_flush
`ifdef HAZARD_PERF_EN
   ,output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_invalid
        $error("hazard_ctrl: CNT_W must be at least 1");
    end

    hz_state_t state_q, state_d;
    hz_ctrl_t  ctrl;
    logic      luse;

    hz_luse_det u_luse_det (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_rd      (ex_rd),
        .ex_is_load (ex_is_load),
        .luse       (luse)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        ctrl    = '0;
        state_d = state_q;
        if (rst) begin
            ctrl    = '0;
            state_d = RUN;
        end else if (dmem_busy) begin
            ctrl.pc_stall = 1'b1;
            ctrl.fd_stall = 1'b1;
            ctrl.de_stall = 1'b1;
            ctrl.em_stall = 1'b1;
            ctrl.mw_flush = 1'b1;
            state_d       = MEMWAIT;
        end else begin
            unique case (state_q)
                MEMWAIT: begin
                    // Release cycle: no stalls, but a resolved redirect still flushes.
                    state_d = RUN;
                    if (ex_redirect) begin
                        ctrl.fd_flush = 1'b1;
                        ctrl.de_flush = 1'b1;
                        state_d       = imem_busy ? REDIR_PEND : RUN;
                    end
                end
                REDIR_PEND: begin
                    if (ex_redirect) begin
                        ctrl.fd_flush = 1'b1;
                        ctrl.de_flush = 1'b1;
                        state_d       = REDIR_PEND;
                    end else begin
                        // Whatever fetch returns now belongs to the old path.
                        ctrl.fd_flush = 1'b1;
                        ctrl.pc_stall = imem_busy;
                        state_d       = imem_busy ? REDIR_PEND : RUN;
                    end
                end
                default: begin
                    if (ex_redirect) begin
                        ctrl.fd_flush = 1'b1;
                        ctrl.de_flush = 1'b1;
                        state_d       = imem_busy ? REDIR_PEND : RUN;
                    end else if (luse) begin
                        ctrl.pc_stall = 1'b1;
                        ctrl.fd_stall = 1'b1;
                        ctrl.de_flush = 1'b1;
                    end else if (imem_busy) begin
                        ctrl.pc_stall = 1'b1;
                        ctrl.fd_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    assign pc_stall = ctrl.pc_stall;
    assign fd_stall = ctrl.fd_stall;
    assign fd_flush = ctrl.fd_flush;
    assign de_stall = ctrl.de_stall;
    assign de_flush = ctrl.de_flush;
    assign em_stall = ctrl.em_stall;
    assign mw_flush = ctrl.mw_flush;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (ctrl.pc_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if ((ctrl.fd_flush || ctrl.de_flush) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, default 32, width of performance counters.
REQ-002 Port: clk  in  1  single clock, all state updates on posedge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: imem_busy  in  1  fetch memory has not returned the current instruction.
REQ-005 Port: dmem_busy  in  1  MEM-stage data access not complete.
REQ-006 Port: id_rs1, id_rs2  in  5 each  decode-stage source registers.
REQ-007 Port: id_use_rs1, id_use_rs2  in  1 each  decode instruction reads rs1/rs2.
REQ-008 Port: ex_rd  in  5  EX-stage destination; ex_is_load  in  1  EX holds a load.
REQ-009 Port: ex_redirect  in  1  branch/jump resolved taken in EX this cycle.
REQ-010 Port: pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, mw_flush  out  1 each  per-stage controls (stall dominates flush inside each pipeline register).
REQ-011 Port: stall_cnt, flush_cnt  out  CNT_W each  present only when HAZARD_PERF_EN is defined.

Function
REQ-012 Outputs are combinational from the current state and inputs; the only registered state is the FSM and the counters.
REQ-013 FSM states: RUN, MEMWAIT, REDIR_PEND.
REQ-014 Priority per cycle: dmem_busy > ex_redirect > load-use > imem_busy.
REQ-015 dmem_busy=1 (any state): pc_stall, fd_stall, de_stall and em_stall =1; mw_flush=1; all other outputs 0; next state MEMWAIT.
REQ-016 MEMWAIT with dmem_busy=0: one release cycle with no stall outputs asserted; next state RUN.
REQ-017 ex_redirect=1, dmem_busy=0: fd_flush=1, de_flush=1, no stall outputs asserted; if imem_busy=1 the same cycle, next state REDIR_PEND, otherwise RUN.
REQ-018 REDIR_PEND: pc_stall=1 and fd_flush=1 while imem_busy=1; the first cycle imem_busy=0 also asserts fd_flush=1 (the stale fetch is discarded); next state RUN.
REQ-019 Load-use hazard = ex_is_load and ex_rd!=0 and ((id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd)).
REQ-020 Load-use in RUN: pc_stall=1, fd_stall=1 and de_flush=1 for exactly one cycle (bubble).
REQ-021 imem_busy=1 in RUN with no higher-priority event: pc_stall=1 and fd_flush=1 (a NOP is inserted into decode).
REQ-022 A register index of x0 never creates a hazard.
REQ-023 Simultaneous ex_redirect and load-use: the redirect wins, and no bubble is inserted.
REQ-024 ex_redirect arriving in REDIR_PEND: the pending state is kept and REQ-017 flushes are applied.

Reset
REQ-025 While rst=1: state=RUN, counters=0, and all control outputs=0.
REQ-026 Reset asserted mid-operation (MEMWAIT or REDIR_PEND) aborts the operation immediately; there is no pending flush or stall after release.

Configuration
REQ-027 Macro HAZARD_PERF_EN defined: stall_cnt increments on each cycle pc_stall=1, and flush_cnt increments on each cycle fd_flush or de_flush=1; both saturate at all-ones.
REQ-028 Macro HAZARD_PERF_EN undefined: the counter ports and logic are absent, and control behaviour is identical.

Structure
REQ-029 The FSM state enum (hz_state_t) and the REG_X0 constant go in the shared pipeline package pipe_pkg.
REQ-030 The load-use comparator is a sub-module named hz_luse_det; there are no other sub-modules.

Verification
REQ-031 Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle of pc_stall=fd_stall=de_flush=1, then all 0.
REQ-032 x0: ex_is_load=1, ex_rd=0, id_rs1=0 -> no stall and no flush.
REQ-033 Redirect with imem_busy=1 for 3 cycles -> fd_flush=de_flush=1 in cycle 0, REDIR_PEND with fd_flush=1 in cycles 1-3, RUN in cycle 4.
REQ-034 dmem_busy=1 for 4 cycles together with a redirect in cycle 1 -> full stall in cycles 0-3 and no flush until dmem_busy=0.
REQ-035 rst pulse during REDIR_PEND -> all outputs 0 and state RUN on release.
REQ-036 HAZARD_PERF_EN defined: 10 load-use events -> stall_cnt=10 and flush_cnt=10; with CNT_W=4 and 20 events -> both counters stay at 15.
